buzzer_tone_gen: RTL and testbench

- Player-feedback output driver: the output end of the user interface, where button conditioning is the input end.
- Game logic issues a one-cycle start request with a tone half-period and a duration. The block drives a square wave on the buzzer pin for that duration, then reports completion.
- Sits between game FSM and board buzzer pin; one clock domain.

---
 rtl/buzzer_tone_gen.sv | 112 +++++++++++
 tb/tb_buzzer_tone_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_tone_gen.sv
// Buzzer tone generator: plays a square wave of a given half-period for a
// duration measured in prescaled ticks, then pulses done once.
module buzzer_tone_gen #(
  parameter int unsigned HALF_W   = 20,
  parameter int unsigned DUR_W    = 12,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [HALF_W-1:0] half_period,
  input  logic [DUR_W-1:0]  duration,
  input  logic              abort,
  output logic              buzz,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_FIN
  } state_t;

  state_t              state;
  logic [HALF_W-1:0]   hp_q;
  logic [DUR_W-1:0]    dur_q;
  logic [HALF_W-1:0]   hp_cnt;
  logic [PRE_W-1:0]    pre_cnt;
  logic [DUR_W-1:0]    tick_cnt;

  logic hp_wrap_c;
  logic pre_wrap_c;
  logic last_tick_c;
  logic zero_args_c;

  // Wrap/terminal detection for the three counters
  always_comb begin
    hp_wrap_c   = (hp_cnt == hp_q - HALF_W'(1));
    pre_wrap_c  = (pre_cnt == PRE_LAST);
    last_tick_c = (tick_cnt == dur_q - DUR_W'(1));
    zero_args_c = (half_period == '0) || (duration == '0);
  end

  // Control FSM with registered outputs; done is emitted on leaving FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      buzz     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hp_q     <= '0;
      dur_q    <= '0;
      hp_cnt   <= '0;
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            hp_q     <= half_period;
            dur_q    <= duration;
            hp_cnt   <= '0;
            pre_cnt  <= '0;
            tick_cnt <= '0;
            if (zero_args_c) begin
              state <= S_FIN;
            end else begin
              state <= S_PLAY;
              busy  <= 1'b1;
              buzz  <= 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            buzz  <= 1'b0;
          end else if (pre_wrap_c && last_tick_c) begin
            state <= S_FIN;
            busy  <= 1'b0;
            buzz  <= 1'b0;
          end else begin
            if (hp_wrap_c) begin
              hp_cnt <= '0;
              buzz   <= ~buzz;
            end else begin
              hp_cnt <= hp_cnt + HALF_W'(1);
            end
            if (pre_wrap_c) begin
              pre_cnt  <= '0;
              tick_cnt <= tick_cnt + DUR_W'(1);
            end else begin
              pre_cnt <= pre_cnt + PRE_W'(1);
            end
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Self-checking bench for buzzer_tone_gen: directed scenarios plus random
// stimulus compared cycle by cycle against an elapsed-time reference model.
module tb_buzzer_tone_gen;

  localparam int unsigned HALF_W   = 20;
  localparam int unsigned DUR_W    = 12;
  localparam int unsigned TICK_DIV = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [HALF_W-1:0] half_period;
  logic [DUR_W-1:0]  duration;
  logic              abort;
  logic              buzz;
  logic              busy;
  logic              done;

  buzzer_tone_gen #(
    .HALF_W  (HALF_W),
    .DUR_W   (DUR_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .half_period(half_period),
    .duration   (duration),
    .abort      (abort),
    .buzz       (buzz),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase of the tone plus clocks elapsed since acceptance
  localparam int P_IDLE = 0, P_PLAY = 1, P_FIN = 2, P_DONE = 3;
  int m_phase = P_IDLE;
  int m_n     = 0;
  int m_h     = 1;
  int m_len   = 0;

  int busy_seen = 0;
  int done_seen = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    logic s, a, r;
    int hp, du;
    logic e_buzz, e_busy, e_done;
    s  = start;
    a  = abort;
    r  = rst;
    hp = int'(half_period);
    du = int'(duration);
    @(posedge clk);
    #1;
    if (r) begin
      m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: begin
          if (s && !a) begin
            if (hp == 0 || du == 0) m_phase = P_FIN;
            else begin
              m_phase = P_PLAY;
              m_h     = hp;
              m_len   = du * TICK_DIV;
              m_n     = 0;
            end
          end else begin
            m_phase = P_IDLE;
          end
        end
        P_PLAY: begin
          if (a) m_phase = P_IDLE;
          else begin
            m_n++;
            if (m_n == m_len) m_phase = P_FIN;
          end
        end
        default: m_phase = P_DONE;
      endcase
    end
    e_busy = (m_phase == P_PLAY);
    e_buzz = e_busy && (((m_n / m_h) % 2) == 0);
    e_done = (m_phase == P_DONE);
    chk({tag, ".buzz"}, int'(buzz), int'(e_buzz));
    chk({tag, ".busy"}, int'(busy), int'(e_busy));
    chk({tag, ".done"}, int'(done), int'(e_done));
    if (busy === 1'b1) busy_seen++;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic idle(input string tag, input int n);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_start(input string tag, input int hp, input int du);
    start       = 1'b1;
    half_period = HALF_W'(hp);
    duration    = DUR_W'(du);
    step(tag);
    start       = 1'b0;
  endtask

  initial begin
    int steps;
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    half_period = '0;
    duration    = '0;
    step("reset");
    step("reset");
    chk("reset_buzz", int'(buzz), 0);
    rst = 1'b0;
    idle("idle", 2);

    // Normal tone, then back-to-back start the cycle after done
    busy_seen = 0;
    done_seen = 0;
    do_start("normal", 3, 4);
    steps = 0;
    while (done !== 1'b1 && steps < 100) begin
      idle("normal", 1);
      steps++;
    end
    chk("normal_done_reached", int'(done), 1);
    chk("normal_busy_cycles", busy_seen, 40);
    idle("b2b", 1);
    do_start("b2b", 2, 1);
    chk("b2b_busy", int'(busy), 1);
    idle("b2b", 15);

    // Zero arguments: done only, two cycles after start
    done_seen = 0;
    busy_seen = 0;
    do_start("zero_hp", 0, 5);
    idle("zero_hp", 4);
    do_start("zero_dur", 3, 0);
    idle("zero_dur", 4);
    chk("zero_busy_cycles", busy_seen, 0);
    chk("zero_done_pulses", done_seen, 2);

    // Abort during play, then restart
    done_seen = 0;
    do_start("abort", 3, 4);
    idle("abort", 10);
    abort = 1'b1;
    step("abort");
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    idle("abort", 1);
    do_start("abort_restart", 3, 4);
    idle("abort_restart", 45);
    chk("abort_done_pulses", done_seen, 1);

    // Start while busy is ignored
    busy_seen = 0;
    do_start("ignore", 3, 4);
    idle("ignore", 5);
    do_start("ignore", 5, 9);
    idle("ignore", 40);
    chk("ignore_busy_cycles", busy_seen, 40);

    // Reset mid-tone
    done_seen = 0;
    do_start("rst_mid", 3, 4);
    idle("rst_mid", 18);
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    chk("rst_mid_busy", int'(busy), 0);
    busy_seen = 0;
    do_start("rst_after", 3, 4);
    idle("rst_after", 45);
    chk("rst_after_busy_cycles", busy_seen, 40);
    chk("rst_after_done", done_seen, 1);

    // Start and abort together in IDLE
    busy_seen = 0;
    done_seen = 0;
    abort = 1'b1;
    do_start("start_abort", 3, 4);
    abort = 1'b0;
    idle("start_abort", 4);
    chk("start_abort_busy", busy_seen, 0);
    chk("start_abort_done", done_seen, 0);

    // Randomized tones with noisy inputs, aborts and resets
    for (int t = 0; t < 40; t++) begin
      do_start("rand", int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      for (int c = 0; c < 45; c++) begin
        start       = ($urandom_range(0, 5) == 0);
        half_period = HALF_W'($urandom_range(0, 7));
        duration    = DUR_W'($urandom_range(0, 3));
        abort       = ($urandom_range(0, 60) == 0);
        rst         = ($urandom_range(0, 150) == 0);
        n_tests++;
        assert (!(busy === 1'b1 && done === 1'b1)) else begin
          n_fail++;
          $error("FAIL rand_busy_done_overlap: busy=%0b done=%0b", busy, done);
        end
        step("rand");
      end
      rst   = 1'b0;
      abort = 1'b0;
      idle("rand_tail", 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
